// File: rtl/cfg_chain_driver_if.sv
// Frame handshake and scan-chain signal bundle for cfg_chain_driver.
// CFG_CRC_EN adds the crc_out signal.
interface cfg_chain_driver_if #(
    parameter int FRAME_BITS = 18,
    parameter int IDX_W      = 4
);
    logic                  start;
    logic                  abort;
    logic [FRAME_BITS-1:0] frame_data;
    logic                  frame_valid;
    logic                  frame_ready;
    logic                  cfg_dout;
    logic                  cfg_en;
    logic                  cfg_chain_rst;
    logic [IDX_W-1:0]      frame_idx;
    logic                  busy;
    logic                  done;
    logic                  aborted;
`ifdef CFG_CRC_EN
    logic [7:0]            crc_out;

    modport master (
        output start, abort, frame_data, frame_valid,
        input  frame_ready, cfg_dout, cfg_en, cfg_chain_rst, frame_idx,
               busy, done, aborted, crc_out
    );
    modport slave (
        input  start, abort, frame_data, frame_valid,
        output frame_ready, cfg_dout, cfg_en, cfg_chain_rst, frame_idx,
               busy, done, aborted, crc_out
    );
`else
    modport master (
        output start, abort, frame_data, frame_valid,
        input  frame_ready, cfg_dout, cfg_en, cfg_chain_rst, frame_idx,
               busy, done, aborted
    );
    modport slave (
        input  start, abort, frame_data, frame_valid,
        output frame_ready, cfg_dout, cfg_en, cfg_chain_rst, frame_idx,
               busy, done, aborted
    );
`endif
endinterface

// File: rtl/cfg_chain_driver.sv
// Serial loader for the fabric configuration chain: clears it, then shifts NUM_FRAMES
// frames MSB-first. Optional CRC-8 of the shifted stream under macro CFG_CRC_EN.
module cfg_chain_driver #(
    parameter int FRAME_BITS = 18,
    parameter int NUM_FRAMES = 9,
    parameter int IDX_W      = 4,
    parameter int BIT_W      = 5
) (
    input  logic              clk,
    input  logic              reset,
    cfg_chain_driver_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_LOAD,
        S_SHIFT,
        S_FINISH
    } state_t;

    localparam logic [BIT_W-1:0] LAST_BIT   = BIT_W'(FRAME_BITS - 1);
    localparam logic [IDX_W-1:0] LAST_FRAME = IDX_W'(NUM_FRAMES - 1);

    state_t                r_state, w_state_nxt;
    logic [FRAME_BITS-1:0] r_shreg, w_shreg_nxt;
    logic [BIT_W-1:0]      r_bitcnt, w_bitcnt_nxt;
    logic [IDX_W-1:0]      r_idx, w_idx_nxt;
    logic                  r_ready, w_ready_nxt;
    logic                  r_dout, w_dout_nxt;
    logic                  r_en, w_en_nxt;
    logic                  r_crst, w_crst_nxt;
    logic                  r_busy, w_busy_nxt;
    logic                  r_done, w_done_nxt;
    logic                  r_aborted, w_aborted_nxt;

    // Outputs are computed for the next state so every port comes straight from a flop.
    always_comb begin
        w_state_nxt   = r_state;
        w_shreg_nxt   = r_shreg;
        w_bitcnt_nxt  = r_bitcnt;
        w_idx_nxt     = r_idx;
        w_ready_nxt   = 1'b0;
        w_dout_nxt    = 1'b0;
        w_en_nxt      = 1'b0;
        w_crst_nxt    = 1'b0;
        w_busy_nxt    = 1'b1;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                w_idx_nxt = '0;
                if (bus.start) begin
                    w_state_nxt = S_CLEAR;
                    w_crst_nxt  = 1'b1;
                end else begin
                    w_busy_nxt  = 1'b0;
                end
            end
            S_CLEAR: begin
                w_state_nxt = S_LOAD;
                w_ready_nxt = 1'b1;
                w_idx_nxt   = '0;
            end
            S_LOAD: begin
                if (bus.frame_valid && r_ready) begin
                    w_state_nxt  = S_SHIFT;
                    w_en_nxt     = 1'b1;
                    w_dout_nxt   = bus.frame_data[FRAME_BITS-1];
                    w_shreg_nxt  = bus.frame_data << 1;
                    w_bitcnt_nxt = '0;
                end else begin
                    w_ready_nxt  = 1'b1;
                end
            end
            S_SHIFT: begin
                if (r_bitcnt == LAST_BIT) begin
                    if (r_idx == LAST_FRAME) begin
                        w_state_nxt = S_FINISH;
                        w_done_nxt  = 1'b1;
                    end else begin
                        w_state_nxt = S_LOAD;
                        w_ready_nxt = 1'b1;
                        w_idx_nxt   = r_idx + IDX_W'(1);
                    end
                end else begin
                    w_en_nxt     = 1'b1;
                    w_dout_nxt   = r_shreg[FRAME_BITS-1];
                    w_shreg_nxt  = r_shreg << 1;
                    w_bitcnt_nxt = r_bitcnt + BIT_W'(1);
                end
            end
            S_FINISH: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
                w_idx_nxt   = '0;
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_busy_nxt  = 1'b0;
            end
        endcase

        // Abort overrides whatever the active state decided, including handshake and completion.
        if (bus.abort && (r_state == S_CLEAR || r_state == S_LOAD || r_state == S_SHIFT)) begin
            w_state_nxt   = S_IDLE;
            w_ready_nxt   = 1'b0;
            w_dout_nxt    = 1'b0;
            w_en_nxt      = 1'b0;
            w_crst_nxt    = 1'b0;
            w_busy_nxt    = 1'b0;
            w_done_nxt    = 1'b0;
            w_aborted_nxt = 1'b1;
            w_idx_nxt     = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_shreg   <= '0;
            r_bitcnt  <= '0;
            r_idx     <= '0;
            r_ready   <= 1'b0;
            r_dout    <= 1'b0;
            r_en      <= 1'b0;
            r_crst    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_aborted <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shreg   <= w_shreg_nxt;
            r_bitcnt  <= w_bitcnt_nxt;
            r_idx     <= w_idx_nxt;
            r_ready   <= w_ready_nxt;
            r_dout    <= w_dout_nxt;
            r_en      <= w_en_nxt;
            r_crst    <= w_crst_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_aborted <= w_aborted_nxt;
        end
    end

    assign bus.frame_ready   = r_ready;
    assign bus.cfg_dout      = r_dout;
    assign bus.cfg_en        = r_en;
    assign bus.cfg_chain_rst = r_crst;
    assign bus.frame_idx     = r_idx;
    assign bus.busy          = r_busy;
    assign bus.done          = r_done;
    assign bus.aborted       = r_aborted;

`ifdef CFG_CRC_EN
    logic [7:0] r_crc;
    logic [7:0] w_crc_step;

    // CRC-8 (x^8+x^2+x+1) folds in the bit currently presented to the chain.
    always_comb begin
        w_crc_step = {r_crc[6:0], 1'b0};
        if (r_crc[7] ^ r_dout) begin
            w_crc_step = w_crc_step ^ 8'h07;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_crc <= '0;
        end else if (w_state_nxt == S_CLEAR) begin
            r_crc <= '0;
        end else if (r_en) begin
            r_crc <= w_crc_step;
        end
    end

    assign bus.crc_out = r_crc;
`endif

endmodule

// File: tb/tb_cfg_chain_driver.sv
// Bench for cfg_chain_driver: small 4x2, default 18x9 with a negedge chain model, 8x1 for CRC.
module tb_cfg_chain_driver;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    cfg_chain_driver_if #(.FRAME_BITS(4),  .IDX_W(1)) s_if ();
    cfg_chain_driver_if #(.FRAME_BITS(18), .IDX_W(4)) d_if ();
    cfg_chain_driver_if #(.FRAME_BITS(8),  .IDX_W(1)) c_if ();

    cfg_chain_driver #(.FRAME_BITS(4), .NUM_FRAMES(2), .IDX_W(1), .BIT_W(2))
        u_s (.clk(clk), .reset(reset), .bus(s_if.slave));
    cfg_chain_driver #(.FRAME_BITS(18), .NUM_FRAMES(9), .IDX_W(4), .BIT_W(5))
        u_d (.clk(clk), .reset(reset), .bus(d_if.slave));
    cfg_chain_driver #(.FRAME_BITS(8), .NUM_FRAMES(1), .IDX_W(1), .BIT_W(3))
        u_c (.clk(clk), .reset(reset), .bus(c_if.slave));

    // Scan chain: negedge D flops, synchronous clear, new bit enters at index 0.
    logic [161:0] chain = '1;
    always @(negedge clk) begin
        if (d_if.cfg_chain_rst) chain <= '0;
        else if (d_if.cfg_en)   chain <= {chain[160:0], d_if.cfg_dout};
    end

    task automatic chk(input string nm, input logic [199:0] act, input logic [199:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    function automatic logic [7:0] pack_s();
        return {s_if.frame_ready, s_if.cfg_dout, s_if.cfg_en, s_if.cfg_chain_rst,
                s_if.frame_idx, s_if.busy, s_if.done, s_if.aborted};
    endfunction

    // Reference model for the 4x2 driver from the protocol rules alone.
    function automatic void model(input logic [3:0] f0, input logic [3:0] f1, input int gap,
                                  input int abt, output logic [7:0] w, output int n,
                                  output int busy, output int dn, output int ab, output int rdy);
        logic [7:0] all;
        all = {f0, f1};
        if (abt < 0) begin
            n = 8; busy = 2 + 2 * (4 + 1) + gap; dn = 1; ab = 0; rdy = 2 + gap;
        end else begin
            n = abt; busy = 2 + n + ((n > 4) ? 1 + gap : 0); dn = 0; ab = 1;
            rdy = (n > 4) ? 2 + gap : 1;
        end
        w = (n == 0) ? 8'h00 : all >> (8 - n);
    endfunction

    function automatic logic [7:0] crc8(input logic [7:0] data);
        logic [7:0] c;
        c = 8'h00;
        for (int i = 7; i >= 0; i--) begin
            if (c[7] ^ data[i]) c = {c[6:0], 1'b0} ^ 8'h07;
            else                c = {c[6:0], 1'b0};
        end
        return c;
    endfunction

    int o_busy, o_done, o_rst, o_abt, o_ready, o_nbits, o_bad;
    logic [7:0] o_word;
    bit o_timeout;

    task automatic run_s(input logic [3:0] f0, input logic [3:0] f1, input int gap,
                         input int abort_at, input bit extra_start, input bit abort_with_start);
        int hs, waitc, guard;
        bit seen, pend;
        hs = 0; waitc = 0; seen = 0; pend = 0;
        o_busy = 0; o_done = 0; o_rst = 0; o_abt = 0; o_ready = 0; o_nbits = 0; o_bad = 0;
        o_word = '0; o_timeout = 1'b1;
        @(negedge clk);
        s_if.start = 1'b1; s_if.abort = abort_with_start;
        s_if.frame_data = f0; s_if.frame_valid = 1'b1;
        for (guard = 0; guard < 200; guard++) begin
            @(negedge clk);
            s_if.start = 1'b0; s_if.abort = 1'b0;
            if (pend) begin
                hs++; pend = 0;
                s_if.frame_valid = 1'b0;
                s_if.frame_data = 4'($urandom);
            end
            if (s_if.busy) begin seen = 1; o_busy++; end
            if (s_if.done) o_done++;
            if (s_if.cfg_chain_rst) o_rst++;
            if (s_if.frame_ready) o_ready++;
            if (s_if.aborted) begin
                o_abt++;
                if (s_if.cfg_en || s_if.frame_ready || s_if.busy) o_bad++;
            end
            if (s_if.cfg_en) begin
                o_word = {o_word[6:0], s_if.cfg_dout};
                o_nbits++;
            end else if (s_if.cfg_dout) begin
                o_bad++;
            end
            if (seen && !s_if.busy) begin o_timeout = 1'b0; break; end
            if ((s_if.cfg_en && o_nbits == abort_at) ||
                (abort_at == 0 && s_if.frame_ready && hs == 0)) s_if.abort = 1'b1;
            if (extra_start && s_if.cfg_en && o_nbits == 3) s_if.start = 1'b1;
            if (s_if.frame_ready && hs == 1 && !s_if.frame_valid) begin
                if (waitc == gap) begin
                    s_if.frame_valid = 1'b1;
                    s_if.frame_data = f1;
                end else begin
                    waitc++;
                end
            end
            if (s_if.frame_ready && s_if.frame_valid) pend = 1;
        end
        s_if.frame_valid = 1'b0; s_if.abort = 1'b0; s_if.start = 1'b0;
    endtask

    task automatic check_s(input string tag, input logic [7:0] w, input int n, input int busy,
                           input int dn, input int ab, input int rdy);
        chk({tag, "_timeout"}, o_timeout, 1'b0);
        chk({tag, "_bits"}, o_word, w);
        chk({tag, "_nbits"}, o_nbits, n);
        chk({tag, "_busy"}, o_busy, busy);
        chk({tag, "_done"}, o_done, dn);
        chk({tag, "_aborted"}, o_abt, ab);
        chk({tag, "_chainrst"}, o_rst, 1);
        chk({tag, "_ready"}, o_ready, rdy);
        chk({tag, "_invariants"}, o_bad, 0);
        chk({tag, "_idle_idx"}, s_if.frame_idx, 1'b0);
    endtask

    typedef struct {
        logic [3:0] f0;
        logic [3:0] f1;
        int         gap;
        int         abt;
        bit         es;
        bit         aws;
        logic [7:0] exp_word;
        int         exp_n;
        int         exp_busy;
        int         exp_done;
        int         exp_abt;
        int         exp_rdy;
    } vec_t;

    task automatic run_d();
        logic [17:0]  fr [9];
        logic [161:0] exp_chain;
        int hs, cyc, first_rst, first_en, nb, bz, dn;
        bit pend, seen;
        exp_chain = '0;
        for (int i = 0; i < 9; i++) begin
            fr[i] = 18'($urandom);
            exp_chain = {exp_chain[143:0], fr[i]};
        end
        hs = 0; pend = 0; seen = 0; nb = 0; bz = 0; dn = 0; first_rst = -1; first_en = -1;
        @(negedge clk);
        d_if.start = 1'b1; d_if.frame_data = fr[0]; d_if.frame_valid = 1'b1;
        for (cyc = 1; cyc <= 400; cyc++) begin
            @(negedge clk);
            d_if.start = 1'b0;
            if (pend) begin
                hs++; pend = 0;
                if (hs < 9) d_if.frame_data = fr[hs];
            end
            if (d_if.cfg_chain_rst && first_rst < 0) first_rst = cyc;
            if (d_if.cfg_en) begin
                nb++;
                if (first_en < 0) first_en = cyc;
            end
            if (d_if.busy) begin seen = 1; bz++; end
            if (d_if.done) dn++;
            if (seen && !d_if.busy) break;
            if (d_if.frame_ready && d_if.frame_valid) pend = 1;
        end
        d_if.frame_valid = 1'b0;
        chk("d_timeout", cyc > 400, 1'b0);
        chk("d_first_rst", first_rst, 1);
        chk("d_first_en", first_en, 3);
        chk("d_nbits", nb, 162);
        chk("d_busy", bz, 173);
        chk("d_done", dn, 1);
        chk("d_chain", chain, exp_chain);
    endtask

    task automatic run_c(input logic [7:0] frame);
        logic [7:0] w, crc_at_done;
        int nb, dn, cyc;
        bit seen;
        w = '0; nb = 0; dn = 0; seen = 0; crc_at_done = '0;
        @(negedge clk);
        c_if.start = 1'b1; c_if.frame_data = frame; c_if.frame_valid = 1'b1;
        for (cyc = 1; cyc <= 50; cyc++) begin
            @(negedge clk);
            c_if.start = 1'b0;
            if (c_if.cfg_en) begin w = {w[6:0], c_if.cfg_dout}; nb++; end
            if (c_if.done) begin
                dn++;
`ifdef CFG_CRC_EN
                crc_at_done = c_if.crc_out;
`endif
            end
            if (c_if.busy) seen = 1;
            if (seen && !c_if.busy) break;
        end
        c_if.frame_valid = 1'b0;
        chk("c_timeout", cyc > 50, 1'b0);
        chk("c_bits", w, frame);
        chk("c_nbits", nb, 8);
        chk("c_done", dn, 1);
`ifdef CFG_CRC_EN
        chk("c_crc_done", crc_at_done, crc8(frame));
        @(negedge clk);
        chk("c_crc_hold", c_if.crc_out, crc8(frame));
`else
        chk("c_crc_unused", crc_at_done, 8'h00);
`endif
    endtask

    initial begin
        vec_t vt [7];
        logic [7:0] w;
        int n, bz, dn, ab, rdy, k;

        vt[0] = '{4'hA, 4'h5, 0, -1, 0, 0, 8'hA5, 8, 12, 1, 0, 2};
        vt[1] = '{4'hA, 4'h5, 5, -1, 0, 0, 8'hA5, 8, 17, 1, 0, 7};
        vt[2] = '{4'h9, 4'h6, 0,  2, 0, 0, 8'h02, 2,  4, 0, 1, 1};
        vt[3] = '{4'h3, 4'hC, 1, -1, 1, 0, 8'h3C, 8, 13, 1, 0, 3};
        vt[4] = '{4'hF, 4'h0, 2, -1, 0, 1, 8'hF0, 8, 14, 1, 0, 4};
        vt[5] = '{4'h6, 4'h9, 0,  0, 0, 0, 8'h00, 0,  2, 0, 1, 1};
        vt[6] = '{4'hC, 4'h3, 3,  8, 0, 0, 8'hC3, 8, 14, 0, 1, 5};

        reset = 1'b1;
        s_if.start = 0; s_if.abort = 0; s_if.frame_data = '0; s_if.frame_valid = 0;
        d_if.start = 0; d_if.abort = 0; d_if.frame_data = '0; d_if.frame_valid = 0;
        c_if.start = 0; c_if.abort = 0; c_if.frame_data = '0; c_if.frame_valid = 0;
        repeat (3) @(negedge clk);
        chk("reset_s", pack_s(), 8'h00);
        chk("reset_d", {d_if.frame_ready, d_if.cfg_dout, d_if.cfg_en, d_if.cfg_chain_rst,
                        d_if.frame_idx, d_if.busy, d_if.done, d_if.aborted}, 11'h000);
        reset = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            run_s(vt[i].f0, vt[i].f1, vt[i].gap, vt[i].abt, vt[i].es, vt[i].aws);
            check_s($sformatf("vec%0d", i), vt[i].exp_word, vt[i].exp_n, vt[i].exp_busy,
                    vt[i].exp_done, vt[i].exp_abt, vt[i].exp_rdy);
        end

        for (int i = 0; i < 12; i++) begin
            logic [3:0] f0, f1;
            int gap, abt;
            f0 = 4'($urandom); f1 = 4'($urandom);
            gap = $urandom_range(0, 4);
            abt = $urandom_range(0, 12);
            if (abt > 8) abt = -1;
            model(f0, f1, gap, abt, w, n, bz, dn, ab, rdy);
            run_s(f0, f1, gap, abt, 1'b0, 1'b0);
            check_s($sformatf("rnd%0d", i), w, n, bz, dn, ab, rdy);
        end

        // Reset in the middle of the first frame's shift.
        @(negedge clk);
        s_if.start = 1'b1; s_if.frame_valid = 1'b1; s_if.frame_data = 4'hA;
        @(negedge clk);
        s_if.start = 1'b0;
        k = 0;
        for (int g = 0; g < 20 && k < 2; g++) begin
            @(negedge clk);
            if (s_if.cfg_en) k++;
        end
        chk("rstmid_reached", k, 2);
        reset = 1'b1; s_if.frame_valid = 1'b0;
        @(negedge clk);
        chk("rstmid_outputs", pack_s(), 8'h00);
        reset = 1'b0;
        @(negedge clk);
        chk("rstmid_idle", pack_s(), 8'h00);
        run_s(4'hA, 4'h5, 0, -1, 1'b0, 1'b0);
        check_s("after_rst", 8'hA5, 8, 12, 1, 0, 2);

        run_d();
        run_c(8'h01);
        run_c(8'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cfg_chain_driver.md
Name: cfg_chain_driver

Overview:
- Serial configuration driver for the 3x3 fabric's configuration scan chain, which is a string of negedge-clocked D flip-flops with synchronous reset.
- Accepts NUM_FRAMES parallel frames (one per CLB/tile) over a valid/ready handshake and shifts them out MSB-first on cfg_dout.
- Drives cfg_dout/cfg_en on posedge so the chain captures mid-cycle on the following negedge.
- Clears the chain before loading and signals completion.

Parameters:
- FRAME_BITS, 18, bits per frame (per-tile config word).
- NUM_FRAMES, 9, frames per full configuration (3x3 tiles).
- IDX_W, 4, width of frame_idx; must satisfy 2^IDX_W >= NUM_FRAMES.
- BIT_W, 5, width of the internal bit counter; must satisfy 2^BIT_W >= FRAME_BITS.

Ports:
- clk  in  1  system clock; all driver logic is posedge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle request to begin a configuration; ignored unless IDLE.
- abort  in  1  stop the current configuration; ignored in IDLE.
- frame_data  in  FRAME_BITS  frame to shift; bit FRAME_BITS-1 is sent first.
- frame_valid  in  1  frame_data valid.
- frame_ready  out  1  driver can accept a frame (LOAD state only).
- cfg_dout  out  1  serial data into the chain head.
- cfg_en  out  1  chain shift enable, qualifies cfg_dout.
- cfg_chain_rst  out  1  chain clear, high for exactly one cycle per configuration.
- frame_idx  out  IDX_W  index of the frame being loaded or shifted.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the last bit has been shifted.
- aborted  out  1  one-cycle pulse when an abort is taken.

Behaviour:
- All outputs are registered.
- Reset values: frame_ready=0, cfg_dout=0, cfg_en=0, cfg_chain_rst=0, frame_idx=0, busy=0, done=0, aborted=0; state=IDLE.
- Reset mid-operation abandons the configuration immediately; no done or aborted pulse is produced.
- States: IDLE, CLEAR, LOAD, SHIFT, FINISH.
- IDLE: start=1 -> CLEAR; busy=1 from the next cycle.
- CLEAR: exactly one cycle with cfg_chain_rst=1 and cfg_en=0 -> LOAD. frame_idx=0.
- LOAD: frame_ready=1 and cfg_en=0.
  - frame_valid & frame_ready at a posedge: capture frame_data into the shift register, bit counter=0, -> SHIFT.
  - Waits indefinitely while frame_valid=0.
- SHIFT: each cycle cfg_en=1 and cfg_dout = shreg[FRAME_BITS-1]; shift left, bit counter +1.
  - After FRAME_BITS cycles of cfg_en=1: if frame_idx==NUM_FRAMES-1 -> FINISH, else frame_idx+1 -> LOAD.
  - Exactly FRAME_BITS enabled bits per frame; cfg_en drops for the LOAD cycle(s) between frames.
- FINISH: done=1 for one cycle, cfg_en=0 -> IDLE; frame_idx returns to 0.
- Latency with frame_valid held high:
  - start sampled at edge N; cfg_chain_rst high for cycle N+1.
  - First cfg_en=1 cycle is N+3.
  - Total busy cycles = 2 + NUM_FRAMES*(FRAME_BITS+1).
- Abort (CLEAR, LOAD or SHIFT): next cycle cfg_en=0, frame_ready=0, aborted=1 for one cycle, -> IDLE.
  - Abort takes priority over a same-cycle handshake and over last-bit completion; no done pulse is produced.
- start while busy: ignored. start and abort in the same cycle in IDLE: start is taken.
- frame_data is sampled only at the handshake; later changes do not affect the shifted bits.
- cfg_dout is 0 whenever cfg_en=0.

Optional Feature:
- Macro: CFG_CRC_EN.
- Defined:
  - Adds output crc_out[7:0]: CRC-8, polynomial 0x07, init 0x00, updated with cfg_dout on every cfg_en=1 cycle, MSB-first.
  - crc_out clears in CLEAR and holds its final value from the done cycle until the next CLEAR or reset.
  - Reset value is 0x00.
- Undefined: no crc_out port and no CRC logic; all other behaviour is identical.

Test Plan:
- FRAME_BITS=4, NUM_FRAMES=2, frames 4'hA then 4'h5 with valid held high; start pulse -> cfg_chain_rst one cycle, cfg_dout under cfg_en = 1,0,1,0 then 0,1,0,1; one LOAD gap between frames; done pulses once; total busy = 12 cycles.
- Same config, frame_valid for frame 1 delayed 5 cycles -> cfg_en stays 0 and frame_ready stays 1 for 5 cycles; stream bits unchanged; done once.
- Abort asserted on the 2nd shift cycle of frame 0 -> cfg_en=0 next cycle; aborted=1 for one cycle; done never asserts; busy=0; a new start fully reloads including cfg_chain_rst.
- Defaults (18x9) with the bench modelling the negedge D-ff chain -> after done, chain contents equal the concatenated frames, frame 0 at the tail; exactly 162 enabled bits.
- Reset asserted mid-SHIFT -> next cycle all outputs at reset values; start while busy is ignored (no extra cfg_chain_rst).
- With CFG_CRC_EN, single 8-bit frame 8'h01 (FRAME_BITS=8, NUM_FRAMES=1) -> crc_out=8'h07 at the done cycle.
